lt24_bus_decoder: RTL and testbench

- Receive-side counterpart of the LT24 write interface driven by the chess engine. Snoops LT24CS_n/LT24Wr_n/LT24RS/LT24Data/LT24Reset_n and decodes ILI9341 command/data writes into pixel writes with absolute (x,y) coordinates.
- Sits beside the display pins in the same clock domain.
- Used for on-chip frame checking and the simulation frame-capture model.

---
 rtl/lt24_bus_decoder_if.sv | 12 +
 rtl/lt24_bus_decoder.sv | 180 ++++++++++++++++++
 tb/tb_lt24_bus_decoder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lt24_bus_decoder_if.sv
// LT24 panel write bus as seen on the display pins; the engine drives it
// (master), the decoder snoops it (slave).
interface lt24_bus_decoder_if;
    logic        LT24CS_n;
    logic        LT24Wr_n;
    logic        LT24RS;
    logic [15:0] LT24Data;
    logic        LT24Reset_n;

    modport master (output LT24CS_n, LT24Wr_n, LT24RS, LT24Data, LT24Reset_n);
    modport slave  (input  LT24CS_n, LT24Wr_n, LT24RS, LT24Data, LT24Reset_n);
endinterface

// File: rtl/lt24_bus_decoder.sv
// Snoops ILI9341 command/data writes on the LT24 bus and turns them into
// pixel writes with absolute (x,y) coordinates inside the current window.
//
// state | meaning
// IDLE  | no command in progress; data writes ignored silently
// CASET | collecting 4 column-window bytes
// PASET | collecting 4 page-window bytes
// RAMWR | each data write is a pixel at the cursor
// OTHER | unsupported command; data writes ignored
module lt24_bus_decoder #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic              clock,
    input  logic              globalReset,
    lt24_bus_decoder_if.slave bus,
    output logic              cmdValid,
    output logic [7:0]        cmdCode,
    output logic              pixelValid,
    output logic [7:0]        pixelX,
    output logic [8:0]        pixelY,
    output logic [15:0]       pixelColour,
    output logic              frameDone,
    output logic              protocolError
);
    localparam logic [15:0] XMAX = 16'(WIDTH - 1);
    localparam logic [15:0] YMAX = 16'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, OTHER} state_t;

    logic        cs_n_r1_q, wr_n_r1_q, rs_r1_q, rst_n_r1_q;
    logic [15:0] data_r1_q;

    state_t      state_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] win_buf_q;
    logic [7:0]  xs_q, xe_q, cx_q;
    logic [8:0]  ys_q, ye_q, cy_q;

    logic        cmd_valid_q, pixel_valid_q, frame_done_q, protocol_error_q;
    logic [7:0]  cmd_code_q, pixel_x_q;
    logic [8:0]  pixel_y_q;
    logic [15:0] pixel_colour_q;

    logic        wr_rise, wr_valid, win_ok, wrap_d;
    logic [15:0] win_start, win_end;
    state_t      cmd_state_d;
    logic [7:0]  cx_d;
    logic [8:0]  cy_d;

    always_ff @(posedge clock) begin
        if (globalReset) begin
            cs_n_r1_q  <= 1'b1;
            wr_n_r1_q  <= 1'b1;
            rs_r1_q    <= 1'b0;
            data_r1_q  <= 16'h0000;
            rst_n_r1_q <= 1'b1;
        end else begin
            cs_n_r1_q  <= bus.LT24CS_n;
            wr_n_r1_q  <= bus.LT24Wr_n;
            rs_r1_q    <= bus.LT24RS;
            data_r1_q  <= bus.LT24Data;
            rst_n_r1_q <= bus.LT24Reset_n;
        end
    end

    always_comb begin
        wr_rise   = !wr_n_r1_q && bus.LT24Wr_n;
        wr_valid  = wr_rise && !cs_n_r1_q && rst_n_r1_q;
        // Three earlier bytes are buffered; the fourth arrives with this write.
        win_start = win_buf_q[23:8];
        win_end   = {win_buf_q[7:0], data_r1_q[7:0]};
        win_ok    = (win_start <= win_end) &&
                    (win_end <= ((state_q == PASET) ? YMAX : XMAX));

        case (data_r1_q[7:0])
            8'h2A:   cmd_state_d = CASET;
            8'h2B:   cmd_state_d = PASET;
            8'h2C:   cmd_state_d = RAMWR;
            default: cmd_state_d = OTHER;
        endcase

        cx_d   = cx_q + 8'd1;
        cy_d   = cy_q;
        wrap_d = 1'b0;
        if (cx_q >= xe_q) begin
            cx_d = xs_q;
            if (cy_q < ye_q) begin
                cy_d = cy_q + 9'd1;
            end else begin
                cy_d   = ys_q;
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (globalReset || !rst_n_r1_q) begin
            state_q        <= IDLE;
            byte_idx_q     <= 2'd0;
            win_buf_q      <= 24'h000000;
            xs_q           <= 8'd0;
            xe_q           <= XMAX[7:0];
            ys_q           <= 9'd0;
            ye_q           <= YMAX[8:0];
            cx_q           <= 8'd0;
            cy_q           <= 9'd0;
            cmd_valid_q    <= 1'b0;
            cmd_code_q     <= 8'h00;
            pixel_valid_q  <= 1'b0;
            pixel_x_q      <= 8'd0;
            pixel_y_q      <= 9'd0;
            pixel_colour_q <= 16'h0000;
            frame_done_q   <= 1'b0;
            // Panel reset leaves the sticky error visible to the checker.
            if (globalReset) begin
                protocol_error_q <= 1'b0;
            end
        end else begin
            cmd_valid_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (wr_valid) begin
                if (!rs_r1_q) begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= data_r1_q[7:0];
                    byte_idx_q  <= 2'd0;
                    state_q     <= cmd_state_d;
                    if (state_q == CASET || state_q == PASET) begin
                        protocol_error_q <= 1'b1;
                    end
                    if (cmd_state_d == RAMWR) begin
                        cx_q <= xs_q;
                        cy_q <= ys_q;
                    end
                end else begin
                    case (state_q)
                        CASET, PASET: begin
                            if (byte_idx_q == 2'd3) begin
                                state_q    <= IDLE;
                                byte_idx_q <= 2'd0;
                                if (!win_ok) begin
                                    protocol_error_q <= 1'b1;
                                end else if (state_q == CASET) begin
                                    xs_q <= win_start[7:0];
                                    xe_q <= win_end[7:0];
                                end else begin
                                    ys_q <= win_start[8:0];
                                    ye_q <= win_end[8:0];
                                end
                            end else begin
                                win_buf_q  <= {win_buf_q[15:0], data_r1_q[7:0]};
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end
                        RAMWR: begin
                            pixel_valid_q  <= 1'b1;
                            pixel_x_q      <= cx_q;
                            pixel_y_q      <= cy_q;
                            pixel_colour_q <= data_r1_q;
                            frame_done_q   <= wrap_d;
                            cx_q           <= cx_d;
                            cy_q           <= cy_d;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign cmdValid      = cmd_valid_q;
    assign cmdCode       = cmd_code_q;
    assign pixelValid    = pixel_valid_q;
    assign pixelX        = pixel_x_q;
    assign pixelY        = pixel_y_q;
    assign pixelColour   = pixel_colour_q;
    assign frameDone     = frame_done_q;
    assign protocolError = protocol_error_q;
endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Self-checking bench: drives LT24 bus writes, queues the expected strobes
// and compares them (including one-cycle latency) as the decoder emits them.
module tb_lt24_bus_decoder;
    logic clock = 1'b0;
    logic globalReset;
    always #5 clock = ~clock;

    lt24_bus_decoder_if bus ();

    logic        cmdValid, pixelValid, frameDone, protocolError;
    logic [7:0]  cmdCode, pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelColour;

    logic        s_cmdValid, s_pixelValid, s_frameDone, s_protocolError;
    logic [7:0]  s_cmdCode, s_pixelX;
    logic [8:0]  s_pixelY;
    logic [15:0] s_pixelColour;

    lt24_bus_decoder dut (
        .clock(clock), .globalReset(globalReset), .bus(bus),
        .cmdValid(cmdValid), .cmdCode(cmdCode), .pixelValid(pixelValid),
        .pixelX(pixelX), .pixelY(pixelY), .pixelColour(pixelColour),
        .frameDone(frameDone), .protocolError(protocolError)
    );

    // Small panel on the same bus so a complete default-window frame fits in the run.
    lt24_bus_decoder #(.WIDTH(8), .HEIGHT(6)) dut_s (
        .clock(clock), .globalReset(globalReset), .bus(bus),
        .cmdValid(s_cmdValid), .cmdCode(s_cmdCode), .pixelValid(s_pixelValid),
        .pixelX(s_pixelX), .pixelY(s_pixelY), .pixelColour(s_pixelColour),
        .frameDone(s_frameDone), .protocolError(s_protocolError)
    );

    typedef struct {
        logic        is_cmd;
        logic [7:0]  code;
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] col;
        logic        fd;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        rs;
        logic [15:0] d;
        logic        has_exp;
        logic [7:0]  x;
        logic [8:0]  y;
        logic        fd;
    } vec_t;

    exp_t sb[$];
    int   pcyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic full_phase = 1'b0;
    int   s_idx = 0;
    int   s_fd_cnt = 0;
    int   s_fd_x = -1;
    int   s_fd_y = -1;

    always @(posedge clock) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, pcyc);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (cmdValid || pixelValid || frameDone) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("latency", pcyc, e.cyc);
                chk("cmdValid", 32'(cmdValid), 32'(e.is_cmd));
                chk("pixelValid", 32'(pixelValid), 32'(!e.is_cmd));
                chk("frameDone", 32'(frameDone), 32'(e.is_cmd ? 1'b0 : e.fd));
                if (e.is_cmd) begin
                    chk("cmdCode", 32'(cmdCode), 32'(e.code));
                end else begin
                    chk("pixelX", 32'(pixelX), 32'(e.x));
                    chk("pixelY", 32'(pixelY), 32'(e.y));
                    chk("pixelColour", 32'(pixelColour), 32'(e.col));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (full_phase && s_pixelValid) begin
            chk("s_pixelX", 32'(s_pixelX), 32'(s_idx % 8));
            chk("s_pixelY", 32'(s_pixelY), 32'((s_idx / 8) % 6));
            chk("s_frameDone", 32'(s_frameDone), 32'((s_idx % 48) == 47));
            if (s_frameDone) begin
                s_fd_cnt++;
                s_fd_x = int'(s_pixelX);
                s_fd_y = int'(s_pixelY);
            end
            s_idx++;
        end
    end

    task automatic wr(input logic rs, input logic [15:0] d, input logic cs_n);
        @(negedge clock);
        bus.LT24CS_n = cs_n;
        bus.LT24RS   = rs;
        bus.LT24Data = d;
        bus.LT24Wr_n = 1'b0;
        @(negedge clock);
        bus.LT24Wr_n = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] c);
        exp_t e;
        wr(1'b0, {8'h00, c}, 1'b0);
        e.is_cmd = 1'b1; e.code = c; e.x = 8'd0; e.y = 9'd0;
        e.col = 16'h0000; e.fd = 1'b0; e.cyc = pcyc + 1;
        sb.push_back(e);
    endtask

    task automatic pix(input logic [15:0] col, input int x, input int y, input logic fd);
        exp_t e;
        wr(1'b1, col, 1'b0);
        e.is_cmd = 1'b0; e.code = 8'h00; e.x = 8'(x); e.y = 9'(y);
        e.col = col; e.fd = fd; e.cyc = pcyc + 1;
        sb.push_back(e);
    endtask

    task automatic dat(input logic [15:0] d);
        wr(1'b1, d, 1'b0);
    endtask

    task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] en);
        cmd(c);
        dat({8'h00, s[15:8]});
        dat({8'h00, s[7:0]});
        dat({8'h00, en[15:8]});
        dat({8'h00, en[7:0]});
    endtask

    task automatic chk_err(input string name, input logic v);
        @(negedge clock);
        chk(name, 32'(protocolError), 32'(v));
    endtask

    task automatic do_reset();
        repeat (2) @(negedge clock);
        globalReset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_cmdValid", 32'(cmdValid), 32'd0);
        chk("rst_cmdCode", 32'(cmdCode), 32'd0);
        chk("rst_pixelValid", 32'(pixelValid), 32'd0);
        chk("rst_pixelX", 32'(pixelX), 32'd0);
        chk("rst_pixelY", 32'(pixelY), 32'd0);
        chk("rst_pixelColour", 32'(pixelColour), 32'd0);
        chk("rst_frameDone", 32'(frameDone), 32'd0);
        chk("rst_protocolError", 32'(protocolError), 32'd0);
        globalReset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl [19];
        tbl[0]  = '{1'b0, 16'h002A, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0000, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[2]  = '{1'b1, 16'h0000, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0000, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0002, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[5]  = '{1'b0, 16'h002B, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0000, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0005, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[8]  = '{1'b1, 16'h0000, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0006, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[10] = '{1'b0, 16'h002C, 1'b0, 8'd0, 9'd0, 1'b0};
        tbl[11] = '{1'b1, 16'hA001, 1'b1, 8'd0, 9'd5, 1'b0};
        tbl[12] = '{1'b1, 16'hA002, 1'b1, 8'd1, 9'd5, 1'b0};
        tbl[13] = '{1'b1, 16'hA003, 1'b1, 8'd2, 9'd5, 1'b0};
        tbl[14] = '{1'b1, 16'hA004, 1'b1, 8'd0, 9'd6, 1'b0};
        tbl[15] = '{1'b1, 16'hA005, 1'b1, 8'd1, 9'd6, 1'b0};
        tbl[16] = '{1'b1, 16'hA006, 1'b1, 8'd2, 9'd6, 1'b1};
        tbl[17] = '{1'b1, 16'hA007, 1'b1, 8'd0, 9'd5, 1'b0};
        tbl[18] = '{1'b0, 16'h0011, 1'b0, 8'd0, 9'd0, 1'b0};

        globalReset     = 1'b1;
        bus.LT24CS_n    = 1'b1;
        bus.LT24Wr_n    = 1'b1;
        bus.LT24RS      = 1'b1;
        bus.LT24Data    = 16'h0000;
        bus.LT24Reset_n = 1'b1;

        // Reset values, then first pixel and its latency.
        do_reset();
        cmd(8'h2C);
        pix(16'hF800, 0, 0, 1'b0);

        // Window fill from the vector table.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            if (!tbl[i].rs) cmd(tbl[i].d[7:0]);
            else if (tbl[i].has_exp) pix(tbl[i].d, int'(tbl[i].x), int'(tbl[i].y), tbl[i].fd);
            else dat(tbl[i].d);
        end
        chk_err("fill_no_error", 1'b0);

        // Window at the panel corner, then rejected windows keep it.
        do_reset();
        win(8'h2A, 16'h00EE, 16'h00EF);
        win(8'h2B, 16'h013E, 16'h013F);
        chk_err("corner_win_ok", 1'b0);
        cmd(8'h2C);
        pix(16'h0101, 238, 318, 1'b0);
        pix(16'h0102, 239, 318, 1'b0);
        pix(16'h0103, 238, 319, 1'b0);
        pix(16'h0104, 239, 319, 1'b1);
        pix(16'h0105, 238, 318, 1'b0);
        win(8'h2A, 16'h0001, 16'h0105);
        chk_err("caset_16bit_over", 1'b1);
        win(8'h2B, 16'h0000, 16'h0140);
        win(8'h2A, 16'h0010, 16'h0005);
        chk_err("bad_window_sticky", 1'b1);
        cmd(8'h2C);
        pix(16'h0201, 238, 318, 1'b0);
        pix(16'h0202, 239, 318, 1'b0);

        // Truncated CASET followed by RAMWR.
        do_reset();
        win(8'h2A, 16'h0004, 16'h0009);
        win(8'h2B, 16'h0002, 16'h0003);
        chk_err("trunc_pre_ok", 1'b0);
        cmd(8'h2A);
        dat(16'h0000);
        dat(16'h0001);
        cmd(8'h2C);
        chk_err("trunc_error", 1'b1);
        pix(16'h0301, 4, 2, 1'b0);
        pix(16'h0302, 5, 2, 1'b0);

        // CS_n high and panel reset mid-RAMWR.
        do_reset();
        win(8'h2A, 16'h0010, 16'h0005);
        chk_err("bad_win_default", 1'b1);
        cmd(8'h2C);
        pix(16'h0401, 0, 0, 1'b0);
        wr(1'b1, 16'hBEEF, 1'b1);
        pix(16'h0402, 1, 0, 1'b0);
        @(negedge clock);
        bus.LT24Reset_n = 1'b0;
        wr(1'b1, 16'h1234, 1'b0);
        wr(1'b0, 16'h002A, 1'b0);
        @(negedge clock);
        bus.LT24Reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("prst_pixelX", 32'(pixelX), 32'd0);
        chk("prst_pixelY", 32'(pixelY), 32'd0);
        chk("prst_pixelColour", 32'(pixelColour), 32'd0);
        chk("prst_cmdCode", 32'(cmdCode), 32'd0);
        chk("prst_protocolError", 32'(protocolError), 32'd1);
        dat(16'h5555);
        chk_err("idle_data_no_error_change", 1'b1);
        cmd(8'h2C);
        for (int i = 0; i < 241; i++) pix(16'(i), i % 240, i / 240, 1'b0);

        // Full default-window frame on the small panel (plus one wrap).
        do_reset();
        full_phase = 1'b1;
        cmd(8'h2C);
        for (int i = 0; i < 49; i++) pix(16'(16'h0800 + i), i, 0, 1'b0);
        repeat (2) @(negedge clock);
        full_phase = 1'b0;
        chk("s_pixel_count", 32'(s_idx), 32'd49);
        chk("s_frameDone_count", 32'(s_fd_cnt), 32'd1);
        chk("s_last_x", 32'(s_fd_x), 32'd7);
        chk("s_last_y", 32'(s_fd_y), 32'd5);

        repeat (3) @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
